// File: rtl/adbg_top_sel_if.sv
// adbg_top_sel_if: bundles the TAP-side and sub-module-side signals of the
// advanced debug top-level selector.
//   TAP side : tdi_i, tdo_o, shift_dr_i, capture_dr_i, update_dr_i,
//              pause_dr_i, debug_select_i
//   Modules  : data_register_o, module_select_o, module_tdo_i,
//              module_inhibit_i, module_id_o, sel_valid_o, sel_error_o
// master drives the selector inputs; slave is the selector itself.
interface adbg_top_sel_if #(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned DATA_LEN    = 53
);
    logic                   tdi_i;
    logic                   tdo_o;
    logic                   shift_dr_i;
    logic                   capture_dr_i;
    logic                   update_dr_i;
    logic                   pause_dr_i;
    logic                   debug_select_i;
    logic [DATA_LEN-1:0]    data_register_o;
    logic [NUM_MODULES-1:0] module_select_o;
    logic [NUM_MODULES-1:0] module_tdo_i;
    logic [NUM_MODULES-1:0] module_inhibit_i;
    logic [ID_WIDTH-1:0]    module_id_o;
    logic                   sel_valid_o;
    logic                   sel_error_o;

    modport master (
        output tdi_i, shift_dr_i, capture_dr_i, update_dr_i, pause_dr_i, debug_select_i,
        output module_tdo_i, module_inhibit_i,
        input  tdo_o, data_register_o, module_select_o, module_id_o, sel_valid_o,
        input  sel_error_o
    );

    modport slave (
        input  tdi_i, shift_dr_i, capture_dr_i, update_dr_i, pause_dr_i, debug_select_i,
        input  module_tdo_i, module_inhibit_i,
        output tdo_o, data_register_o, module_select_o, module_id_o, sel_valid_o,
        output sel_error_o
    );
endinterface

// File: rtl/adbg_top_sel.sv
// adbg_top_sel: parametrised top-level selector for the advanced debug
// interface. Owns the shared DR input shift register, the registered module
// ID with presence checking and a sticky selection-error flag, the one-hot
// module selects and the TDO return mux (status bit when nothing is selected).
//   tck_i : JTAG clock, all state on its rising edge
//   rst_i : asynchronous active-high reset
//   bus   : adbg_top_sel_if.slave (TAP flags, TDI/TDO, module-side signals)
module adbg_top_sel #(
    parameter int unsigned            NUM_MODULES = 4,
    parameter int unsigned            ID_WIDTH    = 2,
    parameter int unsigned            DATA_LEN    = 53,
    parameter logic [NUM_MODULES-1:0] MODULE_MASK = {NUM_MODULES{1'b1}},
    parameter int unsigned            RESET_ID    = 0
) (
    input logic            tck_i,
    input logic            rst_i,
    adbg_top_sel_if.slave  bus
);

    // True only for in-range IDs whose slot is populated.
    function automatic logic slot_present(input int unsigned id);
        logic present;
        present = 1'b0;
        for (int unsigned i = 0; i < NUM_MODULES; i++) begin
            if (id == i) present = MODULE_MASK[i];
        end
        return present;
    endfunction

    localparam logic                RESET_VALID = slot_present(RESET_ID);
    localparam logic [ID_WIDTH-1:0] RESET_ID_W  = ID_WIDTH'(RESET_ID);

    logic [DATA_LEN-1:0]    sr_q;
    logic [ID_WIDTH-1:0]    module_id_q;
    logic                   sel_valid_q;
    logic                   sel_error_q;
    logic                   stat_q;

    logic                   select_cmd;
    logic [ID_WIDTH-1:0]    id_in;
    logic                   inhibit;
    logic                   shift_en;
    logic                   capture_en;
    logic                   select_ev;
    logic                   id_ok;
    logic                   tdo_mod;
    logic [NUM_MODULES-1:0] select_vec;
    logic                   unused_pause;

    assign unused_pause = bus.pause_dr_i;

    assign select_cmd = sr_q[DATA_LEN-1];
    assign id_in      = sr_q[DATA_LEN-2 -: ID_WIDTH];
    // Unpopulated slots cannot block a selection.
    assign inhibit    = |(bus.module_inhibit_i & MODULE_MASK);
    assign shift_en   = bus.debug_select_i & bus.shift_dr_i;
    assign capture_en = bus.debug_select_i & bus.capture_dr_i;
    assign select_ev  = bus.debug_select_i & bus.update_dr_i & select_cmd & ~inhibit;
    assign id_ok      = slot_present(32'(id_in));

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else if (shift_en) begin
            sr_q <= {bus.tdi_i, sr_q[DATA_LEN-1:1]};
        end
    end

    // A rejected ID is still latched so module_id_o shows what was attempted.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            module_id_q <= RESET_ID_W;
            sel_valid_q <= RESET_VALID;
            sel_error_q <= 1'b0;
        end else if (select_ev) begin
            module_id_q <= id_in;
            sel_valid_q <= id_ok;
            sel_error_q <= ~id_ok;
        end
    end

    // Capture wins over shift so the status bit is the first bit out.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= 1'b0;
        end else if (capture_en) begin
            stat_q <= sel_valid_q;
        end else if (shift_en) begin
            stat_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_MODULES; g++) begin : g_select
        assign select_vec[g] = sel_valid_q & (module_id_q == ID_WIDTH'(g));
    end

    always_comb begin
        tdo_mod = 1'b0;
        for (int unsigned i = 0; i < NUM_MODULES; i++) begin
            if (module_id_q == ID_WIDTH'(i)) tdo_mod = bus.module_tdo_i[i];
        end
    end

    assign bus.tdo_o           = sel_valid_q ? tdo_mod : stat_q;
    assign bus.data_register_o = sr_q;
    assign bus.module_select_o = select_vec;
    assign bus.module_id_o     = module_id_q;
    assign bus.sel_valid_o     = sel_valid_q;
    assign bus.sel_error_o     = sel_error_q;

endmodule

// File: tb/tb_adbg_top_sel.sv
// tb_adbg_top_sel: table-driven bench for adbg_top_sel. Instance A uses the
// default geometry with slots 0,1,3 populated; instance B uses 6 modules,
// 3-bit IDs and a 60-bit shift register.
module tb_adbg_top_sel;

    logic tck;
    logic rst;

    adbg_top_sel_if #(.NUM_MODULES(4), .ID_WIDTH(2), .DATA_LEN(53)) ia ();
    adbg_top_sel_if #(.NUM_MODULES(6), .ID_WIDTH(3), .DATA_LEN(60)) ib ();

    adbg_top_sel #(
        .NUM_MODULES(4), .ID_WIDTH(2), .DATA_LEN(53), .MODULE_MASK(4'b1011), .RESET_ID(0)
    ) dut_a (
        .tck_i(tck),
        .rst_i(rst),
        .bus  (ia)
    );

    adbg_top_sel #(
        .NUM_MODULES(6), .ID_WIDTH(3), .DATA_LEN(60), .MODULE_MASK(6'b111111), .RESET_ID(0)
    ) dut_b (
        .tck_i(tck),
        .rst_i(rst),
        .bus  (ib)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       sel;
        logic [1:0] id;
        logic [3:0] inh;
        logic [3:0] exp_sel;
        logic [1:0] exp_id;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_a(input logic [52:0] v);
        ia.debug_select_i = 1'b1;
        for (int k = 0; k < 53; k++) begin
            ia.tdi_i      = v[k];
            ia.shift_dr_i = 1'b1;
            tick();
        end
        ia.shift_dr_i = 1'b0;
        ia.tdi_i      = 1'b0;
    endtask

    task automatic update_a(input logic [3:0] inh);
        ia.module_inhibit_i = inh;
        ia.update_dr_i      = 1'b1;
        tick();
        ia.update_dr_i      = 1'b0;
        ia.module_inhibit_i = 4'b0000;
    endtask

    task automatic shift_b(input logic [59:0] v, input int nbits);
        ib.debug_select_i = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            ib.tdi_i      = v[k];
            ib.shift_dr_i = 1'b1;
            tick();
        end
        ib.shift_dr_i = 1'b0;
        ib.tdi_i      = 1'b0;
    endtask

    task automatic update_b();
        ib.update_dr_i = 1'b1;
        tick();
        ib.update_dr_i = 1'b0;
    endtask

    initial begin
        logic [52:0] va;
        logic [59:0] vb;

        //          sel   id     inh      exp_sel  exp_id valid err
        vecs[0] = '{1'b1, 2'd3, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'd2, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 2'd1, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 2'd0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 2'd3, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 2'd2, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 2'd2, 4'b0010, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 2'd3, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};

        rst = 1'b0;
        ia.tdi_i = 1'b0; ia.shift_dr_i = 1'b0; ia.capture_dr_i = 1'b0; ia.update_dr_i = 1'b0;
        ia.pause_dr_i = 1'b0; ia.debug_select_i = 1'b0;
        ia.module_tdo_i = 4'b0000; ia.module_inhibit_i = 4'b0000;
        ib.tdi_i = 1'b0; ib.shift_dr_i = 1'b0; ib.capture_dr_i = 1'b0; ib.update_dr_i = 1'b0;
        ib.pause_dr_i = 1'b0; ib.debug_select_i = 1'b0;
        ib.module_tdo_i = 6'b000000; ib.module_inhibit_i = 6'b000000;
        #2 rst = 1'b1;
        #2;

        // Reset defaults
        chk("rst_a.sel",   64'(ia.module_select_o), 64'h1);
        chk("rst_a.valid", 64'(ia.sel_valid_o),     64'h1);
        chk("rst_a.err",   64'(ia.sel_error_o),     64'h0);
        chk("rst_a.dr",    64'(ia.data_register_o), 64'h0);
        chk("rst_b.sel",   64'(ib.module_select_o), 64'h1);
        @(posedge tck);
        #1 rst = 1'b0;

        // Table of select commands against instance A
        for (int i = 0; i < 10; i++) begin
            va = '0;
            va[52] = vecs[i].sel;
            va[51:50] = vecs[i].id;
            shift_a(va);
            chk($sformatf("v%0d.dr", i), 64'(ia.data_register_o), 64'(va));
            update_a(vecs[i].inh);
            chk($sformatf("v%0d.sel", i),   64'(ia.module_select_o), 64'(vecs[i].exp_sel));
            chk($sformatf("v%0d.id", i),    64'(ia.module_id_o),     64'(vecs[i].exp_id));
            chk($sformatf("v%0d.valid", i), 64'(ia.sel_valid_o),     64'(vecs[i].exp_valid));
            chk($sformatf("v%0d.err", i),   64'(ia.sel_error_o),     64'(vecs[i].exp_err));
        end

        // debug_select low: shift request must not move sr
        ia.debug_select_i = 1'b0;
        ia.shift_dr_i = 1'b1;
        ia.tdi_i = 1'b1;
        tick();
        ia.shift_dr_i = 1'b0;
        ia.tdi_i = 1'b0;
        chk("nosel.dr", 64'(ia.data_register_o), 64'(va));

        // TDO follows module 3 while it is selected
        ia.module_tdo_i = 4'b1000;
        #1 chk("tdo.m3_hi", 64'(ia.tdo_o), 64'h1);
        ia.module_tdo_i = 4'b0111;
        #1 chk("tdo.m3_lo", 64'(ia.tdo_o), 64'h0);

        // Capture with valid selection: stat loads 1 but TDO still from module
        ia.module_tdo_i = 4'b0000;
        ia.debug_select_i = 1'b1;
        ia.capture_dr_i = 1'b1;
        tick();
        ia.capture_dr_i = 1'b0;
        chk("cap_valid.tdo", 64'(ia.tdo_o), 64'h0);

        // Capture together with an update to absent ID 2: stat takes the
        // pre-edge valid (1) and becomes visible once the selection drops.
        va = '0;
        va[52] = 1'b1;
        va[51:50] = 2'd2;
        shift_a(va);
        ia.capture_dr_i = 1'b1;
        ia.update_dr_i = 1'b1;
        tick();
        ia.capture_dr_i = 1'b0;
        ia.update_dr_i = 1'b0;
        chk("capupd.valid", 64'(ia.sel_valid_o), 64'h0);
        chk("capupd.tdo",   64'(ia.tdo_o),       64'h1);
        ia.shift_dr_i = 1'b1;
        tick();
        ia.shift_dr_i = 1'b0;
        chk("stat_shift.tdo", 64'(ia.tdo_o), 64'h0);

        // With nothing selected the captured status bit is 0
        ia.module_tdo_i = 4'b1111;
        ia.capture_dr_i = 1'b1;
        tick();
        ia.capture_dr_i = 1'b0;
        chk("cap_invalid.tdo", 64'(ia.tdo_o), 64'h0);
        ia.shift_dr_i = 1'b1;
        tick();
        ia.shift_dr_i = 1'b0;
        chk("cap_invalid.tdo2", 64'(ia.tdo_o), 64'h0);

        // Instance B: ID 5 valid, ID 7 and ID 6 out of range
        vb = '0;
        vb[59] = 1'b1;
        vb[58:56] = 3'd5;
        shift_b(vb, 60);
        update_b();
        chk("b5.sel",   64'(ib.module_select_o), 64'h20);
        chk("b5.id",    64'(ib.module_id_o),     64'h5);
        ib.module_tdo_i = 6'b100000;
        #1 chk("b5.tdo", 64'(ib.tdo_o), 64'h1);
        vb[58:56] = 3'd7;
        shift_b(vb, 60);
        update_b();
        chk("b7.err",   64'(ib.sel_error_o),     64'h1);
        chk("b7.sel",   64'(ib.module_select_o), 64'h0);
        vb[58:56] = 3'd6;
        shift_b(vb, 60);
        update_b();
        chk("b6.err",   64'(ib.sel_error_o),     64'h1);
        chk("b6.valid", 64'(ib.sel_valid_o),     64'h0);

        // Async reset mid-shift
        vb = '1;
        shift_b(vb, 20);
        rst = 1'b1;
        #1;
        chk("arst.dr",    64'(ib.data_register_o), 64'h0);
        chk("arst.sel",   64'(ib.module_select_o), 64'h1);
        chk("arst.id",    64'(ib.module_id_o),     64'h0);
        chk("arst.err",   64'(ib.sel_error_o),     64'h0);
        chk("arst.valid", 64'(ib.sel_valid_o),     64'h1);
        tick();
        rst = 1'b0;
        // sr is empty, so an update is not a select command
        update_b();
        chk("arst_upd.sel", 64'(ib.module_select_o), 64'h1);
        chk("arst_upd.err", 64'(ib.sel_error_o),     64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adbg_top_sel.md
# adbg_top_sel

Parametrised top-level selector for the advanced debug interface. It sits between the TAP controller and up to NUM_MODULES debug sub-modules (WishBone, CPUs, JSP, and so on). It owns the shared DR input shift register and the registered module-ID, and it drives the one-hot module selects and the TDO return mux. Compared with the fixed four-module selector, it adds:
- a configurable module count and ID width;
- a presence mask, so absent modules are never selected;
- a sticky selection-error flag;
- a top-level status bit shifted out when no module is selected.

## Interface
Parameters:
- NUM_MODULES, 4: number of sub-module slots; must satisfy NUM_MODULES ≤ 2^ID_WIDTH.
- ID_WIDTH, 2: width of the module-ID field.
- DATA_LEN, 53: length of the input shift register; must satisfy DATA_LEN ≥ ID_WIDTH+1.
- MODULE_MASK, {NUM_MODULES{1'b1}}: bit i = 1 means slot i is populated.
- RESET_ID, 0: module ID loaded at reset.

Ports:
- tck_i  in  1  JTAG clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- tdi_i  in  1  JTAG serial data in.
- tdo_o  out  1  JTAG serial data out (combinational).
- shift_dr_i, capture_dr_i, update_dr_i, pause_dr_i  in  1 each  TAP state flags. pause_dr_i is unused and reserved.
- debug_select_i  in  1  debug IR selected in TAP.
- data_register_o  out  DATA_LEN  input shift register contents, fanned out to every sub-module.
- module_select_o  out  NUM_MODULES  one-hot module select; all zero when no valid module is selected.
- module_tdo_i  in  NUM_MODULES  per-module TDO.
- module_inhibit_i  in  NUM_MODULES  per-module request to block a new selection.
- module_id_o  out  ID_WIDTH  registered module ID.
- sel_valid_o  out  1  the registered ID refers to a populated slot.
- sel_error_o  out  1  sticky: the last selection attempt named an absent or out-of-range ID.

## Operation
**Shift register (sr)**
- On each tck edge with debug_select_i & shift_dr_i: sr <= {tdi_i, sr[DATA_LEN-1:1]}.
- Otherwise sr holds.
- data_register_o = sr.

**Field decode**
- select_cmd = sr[DATA_LEN-1].
- id_in = sr[DATA_LEN-2 -: ID_WIDTH].

**Selection inhibit**
- inhibit = |(module_inhibit_i & MODULE_MASK). Inhibit inputs of unpopulated slots are ignored.

**Selection event**
- A selection event is debug_select_i & update_dr_i & select_cmd & !inhibit at a tck edge.
- If id_in < NUM_MODULES and MODULE_MASK[id_in] = 1:
  - module_id <= id_in, sel_valid <= 1, sel_error <= 0.
- Otherwise:
  - module_id <= id_in, sel_valid <= 0, sel_error <= 1.
- A selection event with inhibit = 1 changes nothing.
- An update with select_cmd = 0 changes nothing; it is a sub-module command.

**Module select**
- module_select_o[i] = sel_valid & (module_id == i).

**Status bit register (stat)**
- On debug_select_i & capture_dr_i: stat <= sel_valid.
- On debug_select_i & shift_dr_i: stat <= 0.
- Capture takes priority if both are asserted.

**TDO mux**
- tdo_o = sel_valid ? module_tdo_i[module_id] : stat.

**Reset**
- sr = 0.
- module_id = RESET_ID.
- sel_valid = MODULE_MASK[RESET_ID] (0 if RESET_ID ≥ NUM_MODULES).
- sel_error = 0.
- stat = 0.
- Consequently module_select_o = one-hot RESET_ID when that slot is populated, else 0.
- tdo_o follows from the mux.

## Timing
- All registers update on the rising tck edge. Reset is asynchronous and takes effect immediately.
- Reset asserted mid-shift discards the partial command. No selection occurs until a full new update.
- Shift latency: the bit on tdi_i at edge k reaches sr[DATA_LEN-1] after edge k. After DATA_LEN shifts, the first bit is at sr[0].
- Selection latency: module_select_o, module_id_o, sel_valid_o and sel_error_o change after the same edge that samples update_dr_i. There are no extra cycles.
- Simultaneous shift_dr_i and update_dr_i cannot occur from a legal TAP. If forced, the shift and the selection both use the pre-edge sr.
- With debug_select_i = 0, sr, stat and the selection state all hold.
- The tdo_o mux is combinational. It switches in the same cycle as module_id/sel_valid.

## Test plan
1. **Reset defaults:** assert rst_i, MODULE_MASK = 4'b1011, RESET_ID = 0 -> module_select_o = 4'b0001, sel_valid_o = 1, sel_error_o = 0, data_register_o = 0.
2. **Valid selection:** shift 53 bits with sr[52] = 1, sr[51:50] = 2'b11, then pulse update_dr_i -> after that edge module_id_o = 3, module_select_o = 4'b1000, and tdo_o tracks module_tdo_i[3].
3. **Absent module:** MODULE_MASK = 4'b1011, select ID 2 -> sel_valid_o = 0, sel_error_o = 1, module_select_o = 0. Then capture_dr + shift: tdo_o = 0, then 0. A following select of ID 1 -> sel_error_o = 0, module_select_o = 4'b0010.
4. **Inhibit:** module_inhibit_i = 4'b0010 from a populated slot, select ID 0 -> no change. With inhibit only on an unpopulated slot (bit 2 of mask 1011), the select is accepted.
5. **Status bit:** with a valid module selected, assert capture_dr then shift once -> tdo_o equals module_tdo_i[id], and stat is ignored. With sel_valid = 0, the first tdo_o bit is 0.
6. **Parametrisation and async reset:** NUM_MODULES = 6, ID_WIDTH = 3, DATA_LEN = 60. Select ID 5 -> module_select_o = 6'b100000. Select ID 7 -> sel_error_o = 1. Assert rst_i mid-shift -> all state returns to reset values immediately.
